// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// Optional feature macro: MULTICYCLE_CONTROL_JUMP_EN adds the JUMP state.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        ,
        JUMP   = 4'd9
`endif
    } state_e;

    // Opcodes
    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] NOP   = 6'b100000;
    localparam logic [5:0] J     = 6'b000010;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that stall on mem_ready and are watched by the wait timer
    function automatic logic is_mem_wait(input state_e s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter with timeout compare and sticky error flag.
module mc_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,      // a memory state waited this cycle
    input  logic clr_i,      // completion, state change or forced restart
    output logic timeout_o,  // counter has hit the limit
    output logic err_o       // sticky timeout flag
);

    localparam logic [3:0] LIMIT = 4'(MEM_TIMEOUT);

    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    // Counter next state; clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (clr_i) begin
            cnt_d = 4'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == LIMIT) err_d = 1'b1;
        end
    end

    // Counter and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign timeout_o = (cnt_q == LIMIT);
    assign err_o     = err_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Optional feature macro: MULTICYCLE_CONTROL_JUMP_EN enables opcode J (JUMP state).
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal,
    output logic       mem_err
);

    state_e     state_q, state_d;
    logic [5:0] opc_q, opc_d;
    logic       in_wait;
    logic       timeout;
    logic       tmr_clr;

    // zero is consumed by the datapath alongside pc_write_cond, not here
    logic unused_zero;
    assign unused_zero = zero;

    assign in_wait = is_mem_wait(state_q);
    assign tmr_clr = (in_wait & mem_ready) | (state_d != state_q) | timeout;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_i     (in_wait & ~mem_ready),
        .clr_i     (tmr_clr),
        .timeout_o (timeout),
        .err_o     (mem_err)
    );

    // State and latched-opcode registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            opc_q   <= 6'd0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
        end
    end

    // Next-state logic, opcode latch and illegal-opcode pulse
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        illegal = 1'b0;
        case (state_q)
            FETCH:  if (mem_ready) state_d = DECODE;
            DECODE: begin
                opc_d = opcode;
                case (opcode)
                    RTYPE:   state_d = EXEC;
                    LW, SW:  state_d = MEMADR;
                    BEQ:     state_d = BRANCH;
                    NOP:     state_d = FETCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
                    J:       state_d = JUMP;
`else
                    J: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
`endif
                    default: begin
                        state_d = FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            MEMADR: state_d = (opc_q == LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) state_d = MEMWB;
            MEMWB:  state_d = FETCH;
            MEMWR:  if (mem_ready) state_d = FETCH;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            JUMP:   state_d = FETCH;
`endif
            default: state_d = FETCH;
        endcase
        // A stuck memory access abandons the instruction
        if (timeout) state_d = FETCH;
    end

    // Moore output decode; memory strobes drop on the timeout cycle
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        case (state_q)
            FETCH: begin
                mem_read  = ~timeout;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready & ~timeout;
                pc_write  = mem_ready & ~timeout;
            end
            DECODE: alu_src_b = SRCB_SEXT_SH2;
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SEXT;
            end
            MEMRD: begin
                mem_read = ~timeout;
                iord     = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEMWR: begin
                mem_write = ~timeout;
                iord      = 1'b1;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
            end
`ifdef MULTICYCLE_CONTROL_JUMP_EN
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
`endif
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control.
module tb_multicycle_control;

    logic       clk, rst_n;
    logic [5:0] opcode;
    logic       zero, mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic       illegal, mem_err;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal(illegal), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        int          lat;     // cycles FETCH entry to FETCH entry
        logic [31:0] seq;     // visited states, one nibble each, oldest first
        int          ill;     // cycles with illegal high
        logic [15:0] rw_m;    // states in which reg_write was seen
        logic [15:0] mtr_m;   // states in which mem_to_reg was seen
        int          mw;      // cycles with mem_write high
        logic [15:0] pwc_m;   // states in which pc_write_cond was seen
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Advance (at negedges) until the state matches, bounded
    task automatic wait_state(input logic [3:0] t, input string name);
        int n = 0;
        while (state !== t && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {28'd0, state}, {28'd0, t});
    endtask

    // Run one instruction from a FETCH cycle back to the next FETCH entry
    task automatic run_vec(input int i);
        int          n = 0, ill = 0, mw = 0;
        logic [31:0] seq = 0;
        logic [15:0] rw_m = 0, mtr_m = 0, pwc_m = 0;
        opcode    = vt[i].op;
        mem_ready = 1'b1;
        do begin
            seq = (seq << 4) | {28'd0, state};
            n++;
            if (illegal)       ill++;
            if (mem_write)     mw++;
            if (reg_write)     rw_m[state]  = 1'b1;
            if (mem_to_reg)    mtr_m[state] = 1'b1;
            if (pc_write_cond) pwc_m[state] = 1'b1;
            @(negedge clk);
        end while (state != 4'd0 && n < 12);
        chk({vt[i].name, " seq"},   seq,            vt[i].seq);
        chk({vt[i].name, " lat"},   n,              vt[i].lat);
        chk({vt[i].name, " ill"},   ill,            vt[i].ill);
        chk({vt[i].name, " rw"},    {16'd0, rw_m},  {16'd0, vt[i].rw_m});
        chk({vt[i].name, " mtr"},   {16'd0, mtr_m}, {16'd0, vt[i].mtr_m});
        chk({vt[i].name, " mw"},    mw,             vt[i].mw);
        chk({vt[i].name, " pwc"},   {16'd0, pwc_m}, {16'd0, vt[i].pwc_m});
    endtask

    initial begin
        int mwc;
        vt[0] = '{"RTYPE", 6'b000000, 4, 32'h0167,  0, 16'h0080, 16'h0000, 0, 16'h0000};
        vt[1] = '{"LW",    6'b100011, 5, 32'h01234, 0, 16'h0010, 16'h0010, 0, 16'h0000};
        vt[2] = '{"SW",    6'b101011, 4, 32'h0125,  0, 16'h0000, 16'h0000, 1, 16'h0000};
        vt[3] = '{"BEQ",   6'b000100, 3, 32'h018,   0, 16'h0000, 16'h0000, 0, 16'h0100};
        vt[4] = '{"NOP",   6'b100000, 2, 32'h01,    0, 16'h0000, 16'h0000, 0, 16'h0000};
        vt[5] = '{"ILL",   6'b111111, 2, 32'h01,    1, 16'h0000, 16'h0000, 0, 16'h0000};
`ifdef MULTICYCLE_CONTROL_JUMP_EN
        vt[6] = '{"J",     6'b000010, 3, 32'h019,   0, 16'h0000, 16'h0000, 0, 16'h0000};
`else
        vt[6] = '{"J",     6'b000010, 2, 32'h01,    1, 16'h0000, 16'h0000, 0, 16'h0000};
`endif

        // Reset state: FETCH, outputs at FETCH values
        rst_n = 1'b0; opcode = 6'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst state",    {28'd0, state}, 32'd0);
        chk("rst mem_err",  {31'd0, mem_err}, 32'd0);
        chk("rst illegal",  {31'd0, illegal}, 32'd0);
        chk("rst mem_read", {31'd0, mem_read}, 32'd1);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(i);

        // BEQ decode values in BRANCH
        opcode = 6'b000100; mem_ready = 1'b1;
        wait_state(4'd8, "beq reach");
        chk("beq alu_op",    {30'd0, alu_op},    32'd1);
        chk("beq pc_source", {30'd0, pc_source}, 32'd1);
        chk("beq pwc",       {31'd0, pc_write_cond}, 32'd1);
        @(negedge clk);
        chk("beq back", {28'd0, state}, 32'd0);

`ifdef MULTICYCLE_CONTROL_JUMP_EN
        opcode = 6'b000010;
        wait_state(4'd9, "j reach");
        chk("j pc_source", {30'd0, pc_source}, 32'd2);
        chk("j pc_write",  {31'd0, pc_write},  32'd1);
        @(negedge clk);
`else
        opcode = 6'b000010;
        @(negedge clk);
        chk("j illegal", {31'd0, illegal}, 32'd1);
        @(negedge clk);
`endif
        chk("j back", {28'd0, state}, 32'd0);

        // SW stalled three cycles in MEMWR
        opcode = 6'b101011; mem_ready = 1'b1;
        wait_state(4'd5, "sw reach");
        mwc = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_write) mwc++;
            mem_ready = (i == 3);
            @(negedge clk);
        end
        chk("sw stall mw",    mwc, 4);
        chk("sw stall state", {28'd0, state}, 32'd0);
        chk("sw stall err",   {31'd0, mem_err}, 32'd0);

        // Reset in the middle of LW abandons it
        opcode = 6'b100011; mem_ready = 1'b1;
        wait_state(4'd3, "lw reach");
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst state", {28'd0, state}, 32'd0);
        chk("mid rst iord",  {31'd0, iord},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // FETCH timeout with mem_ready held low
        repeat (14) @(negedge clk);
        chk("to err@14",  {31'd0, mem_err},  32'd0);
        chk("to rd@14",   {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        chk("to err@15",  {31'd0, mem_err},  32'd1);
        chk("to rd drop", {31'd0, mem_read}, 32'd0);
        @(negedge clk);
        chk("to state",   {28'd0, state},    32'd0);
        chk("to rd back", {31'd0, mem_read}, 32'd1);
        repeat (5) @(negedge clk);
        chk("to sticky",  {31'd0, mem_err},  32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("to async clr", {31'd0, mem_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, the number of consecutive memory wait cycles before the error exit (range 1..15).
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  6  instruction opcode; sampled in DECODE only.
REQ-006 zero  input  1  ALU zero flag; passed through, never sampled.
REQ-007 mem_ready  input  1  memory completes the current read or write this cycle.
REQ-008 Outputs, each 1 bit: pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-009 Outputs, each 2 bits: alu_src_b (00 reg, 01 const 4, 10 signext, 11 signext<<2), alu_op (00 add, 01 sub, 10 funct), pc_source (00 ALU, 01 ALUOut, 10 jump target).
REQ-010 state  output  4  current state encoding, for debug.
REQ-011 illegal  output  1  one-cycle pulse when the opcode is not recognised.
REQ-012 mem_err  output  1  sticky flag for a memory timeout.

Function
REQ-013 Moore FSM; all outputs are functions of state only, except the gating named below.
REQ-014 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9.
REQ-015 Any output not listed for a state is 0.
REQ-016 FETCH
- Drives mem_read=1, alu_src_b=01, alu_op=00.
- ir_write and pc_write are 1 only while mem_ready=1.
- Holds until mem_ready, then goes to DECODE.
REQ-017 DECODE
- Drives alu_src_b=11, alu_op=00.
- Next state by opcode: 000000 to EXEC; 100011 or 101011 to MEMADR; 000100 to BRANCH; 100000 (NOP) to FETCH.
- Any other opcode goes to FETCH with illegal=1 for that cycle.
REQ-018 MEMADR
- Drives alu_src_a=1, alu_src_b=10.
- Goes to MEMRD if the opcode latched in DECODE was LW, else to MEMWR.
REQ-019 MEMRD drives mem_read=1, iord=1; holds until mem_ready, then goes to MEMWB.
REQ-020 MEMWB drives reg_write=1, mem_to_reg=1, then goes to FETCH.
REQ-021 MEMWR drives mem_write=1, iord=1; holds until mem_ready, then goes to FETCH.
REQ-022 EXEC drives alu_src_a=1, alu_op=10, then goes to ALUWB.
REQ-023 ALUWB drives reg_write=1, reg_dst=1, then goes to FETCH.
REQ-024 BRANCH drives alu_src_a=1, alu_op=01, pc_write_cond=1, pc_source=01, then goes to FETCH.
REQ-025 The opcode is latched into an internal 6-bit register in DECODE; later states use only the latched value.
REQ-026 Latency in cycles, FETCH entry back to FETCH entry, with mem_ready held high:
- R-type 4, LW 5, SW 4, BEQ 3, NOP 2, illegal 2.
REQ-027 Memory wait counter
- 4 bits; increments each cycle that FETCH, MEMRD or MEMWR waits with mem_ready=0.
- Clears on mem_ready or on any state change.
REQ-028 When the counter reaches MEM_TIMEOUT:
- mem_err sets and stays set until reset.
- The FSM forces FETCH next cycle; the memory strobes drop.
REQ-029 mem_ready asserted outside FETCH, MEMRD and MEMWR is ignored.

Reset
REQ-030 Asynchronous assertion gives state=FETCH, the latched opcode=0, the counter=0, mem_err=0 and illegal=0.
REQ-031 Reset mid-transaction abandons it; outputs take their FETCH values during reset.

Configuration
REQ-032 With MULTICYCLE_CONTROL_JUMP_EN defined:
- Opcode 000010 goes from DECODE to JUMP.
- JUMP drives pc_write=1, pc_source=10, then goes to FETCH; J latency is 3.
REQ-033 With MULTICYCLE_CONTROL_JUMP_EN undefined, JUMP does not exist and 000010 is illegal.

Structure
REQ-034 Package mc_ctrl_pkg holds the state type, the opcode constants (RTYPE, LW, SW, BEQ, NOP, J), and the alu_op, alu_src_b and pc_source encodings.
REQ-035 Sub-module mc_wait_timer holds the wait counter and timeout compare.

Verification
REQ-036 Reset, then LW (100011) with mem_ready=1:
- state sequence 0,1,2,3,4,0.
- reg_write=1 and mem_to_reg=1 in state 4 only.
REQ-037 BEQ (000100), mem_ready=1:
- 3 cycles; pc_write_cond=1 and alu_op=01 in state 8.
REQ-038 SW with mem_ready low 3 cycles in MEMWR:
- mem_write stays high 4 cycles, then state returns to 0; mem_err=0.
REQ-039 Opcode 111111:
- illegal pulses 1 cycle in DECODE; next state 0; no reg_write or mem_write.
REQ-040 mem_ready held low in FETCH with MEM_TIMEOUT=15:
- mem_err=1 after 15 wait cycles and stays high.
- rst_n low clears it asynchronously.
REQ-041 Opcode 000010:
- With MULTICYCLE_CONTROL_JUMP_EN: state 9, pc_source=10.
- Without it: illegal pulse.
